// File: rtl/vga_bus_pkg.sv
// Shared types and constants for the VGA controller register port.
// Select, acknowledge and interrupt lines on this port are all active-low.
package vga_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_RELEASE = 2'd2
    } bridge_state_e;

    localparam logic [7:0] REG_MODE_SELECT = 8'h00;
    localparam logic [7:0] REG_MODE_CONFIG = 8'h01;
    localparam logic [7:0] REG_SCROLL_X    = 8'h02;
    localparam logic [7:0] REG_SCROLL_Y    = 8'h03;
    localparam logic [7:0] REG_MISC_0      = 8'h04;
    localparam logic [7:0] REG_RASTER_LO   = 8'h05;
    localparam logic [7:0] REG_RASTER_HI   = 8'h06;

    localparam logic SEL_ON  = 1'b0;
    localparam logic SEL_OFF = 1'b1;
    localparam logic ACK_ON  = 1'b0;
    localparam logic IRQ_ON  = 1'b0;

endpackage

// File: rtl/vga_bus_timer.sv
// Loadable down-counter that bounds each handshake phase.
// It stops at zero; expired is high whenever the count has reached zero.
module vga_bus_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_main,
    input  logic             reset_in_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_main or negedge reset_in_n) begin
        if (!reset_in_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vga_host_bridge.sv
// Host valid/ready request to VGA controller select/ack handshake bridge.
// Define VGA_BRIDGE_IRQ_AUTOACK_EN to have the bridge auto-read REG_MISC_0 on interrupt.
module vga_host_bridge
    import vga_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255  // legal range 2..65535
) (
    input  logic       clk_main,
    input  logic       reset_in_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic       vga_select,
    output logic       cpu_rw,
    output logic [7:0] cpu_a_bus,
    output logic [7:0] cpu_d_bus,
    input  logic       cpu_ack,
    input  logic [7:0] vga_d_in,
    input  logic       vga_interrupt,
    output logic       irq_pending,
    output logic [7:0] irq_status,
    input  logic       irq_clear,
    output logic [1:0] state_dbg
);

    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

    // Host handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; rsp_valid is a single-cycle pulse with no back-pressure.
    bridge_state_e state;
    logic          xfer_auto;
    logic [7:0]    rd_data;
    logic          auto_start;
    logic          timer_load;
    logic          timer_expired;

`ifdef VGA_BRIDGE_IRQ_AUTOACK_EN
    assign auto_start = (state == ST_IDLE) && (vga_interrupt == IRQ_ON) && !irq_pending;
`else
    assign auto_start = 1'b0;
`endif

    assign req_ready  = (state == ST_IDLE) && !auto_start;
    assign state_dbg  = state;
    assign timer_load = (state == ST_IDLE && (auto_start || req_valid)) ||
                        (state == ST_SELECT && cpu_ack == ACK_ON);

    vga_bus_timer #(.WIDTH(16)) u_timer (
        .clk_main   (clk_main),
        .reset_in_n (reset_in_n),
        .load       (timer_load),
        .load_value (TIMER_LOAD),
        .count_en   (state != ST_IDLE),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk_main or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state      <= ST_IDLE;
            xfer_auto  <= 1'b0;
            rd_data    <= 8'h00;
            vga_select <= SEL_OFF;
            cpu_rw     <= 1'b1;
            cpu_a_bus  <= 8'h00;
            cpu_d_bus  <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_error  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (auto_start) begin
                        cpu_rw     <= 1'b1;
                        cpu_a_bus  <= REG_MISC_0;
                        cpu_d_bus  <= 8'h00;
                        vga_select <= SEL_ON;
                        xfer_auto  <= 1'b1;
                        state      <= ST_SELECT;
                    end else if (req_valid) begin
                        cpu_rw     <= req_rw;
                        cpu_a_bus  <= req_addr;
                        cpu_d_bus  <= req_wdata;
                        vga_select <= SEL_ON;
                        xfer_auto  <= 1'b0;
                        state      <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cpu_ack == ACK_ON) begin
                        rd_data    <= cpu_rw ? vga_d_in : 8'h00;
                        vga_select <= SEL_OFF;
                        state      <= ST_RELEASE;
                    end else if (timer_expired) begin
                        vga_select <= SEL_OFF;
                        rsp_valid  <= !xfer_auto;
                        rsp_error  <= !xfer_auto;
                        state      <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (cpu_ack != ACK_ON) begin
                        rsp_valid <= !xfer_auto;
                        rsp_rdata <= xfer_auto ? 8'h00 : rd_data;
                        state     <= ST_IDLE;
                    end else if (timer_expired) begin
                        rsp_valid <= !xfer_auto;
                        rsp_error <= !xfer_auto;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VGA_BRIDGE_IRQ_AUTOACK_EN
    logic auto_done;
    assign auto_done = (state == ST_RELEASE) && (cpu_ack != ACK_ON) && xfer_auto;

    // A completing auto-read outranks a simultaneous clear.
    always_ff @(posedge clk_main or negedge reset_in_n) begin
        if (!reset_in_n) begin
            irq_pending <= 1'b0;
            irq_status  <= 8'h00;
        end else if (auto_done) begin
            irq_pending <= 1'b1;
            irq_status  <= rd_data;
        end else if (irq_clear) begin
            irq_pending <= 1'b0;
        end
    end
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear;
    assign irq_status       = 8'h00;

    always_ff @(posedge clk_main or negedge reset_in_n) begin
        if (!reset_in_n) begin
            irq_pending <= 1'b0;
        end else begin
            irq_pending <= (vga_interrupt == IRQ_ON);
        end
    end
`endif

endmodule

// File: tb/tb_vga_host_bridge.sv
// Directed bench for vga_host_bridge against a registered-ack responder model.
// Responder modes: 0 echoes select one cycle later, 1 never acks, 2 holds ack low once asserted.
module tb_vga_host_bridge;

    logic       clk_main = 1'b0;
    logic       reset_in_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic       vga_select;
    logic       cpu_rw;
    logic [7:0] cpu_a_bus;
    logic [7:0] cpu_d_bus;
    logic       cpu_ack = 1'b1;
    logic [7:0] vga_d_in;
    logic       vga_interrupt;
    logic       irq_pending;
    logic [7:0] irq_status;
    logic       irq_clear;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int resp_mode = 0;

    vga_host_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_main      (clk_main),
        .reset_in_n    (reset_in_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .vga_select    (vga_select),
        .cpu_rw        (cpu_rw),
        .cpu_a_bus     (cpu_a_bus),
        .cpu_d_bus     (cpu_d_bus),
        .cpu_ack       (cpu_ack),
        .vga_d_in      (vga_d_in),
        .vga_interrupt (vga_interrupt),
        .irq_pending   (irq_pending),
        .irq_status    (irq_status),
        .irq_clear     (irq_clear),
        .state_dbg     (state_dbg)
    );

    // clock
    always #5 clk_main = ~clk_main;

    // registered responder
    always @(posedge clk_main) begin
        case (resp_mode)
            0:       cpu_ack <= vga_select;
            1:       cpu_ack <= 1'b1;
            default: if (!vga_select) cpu_ack <= 1'b0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Presents one request at the current negedge and follows it to its response.
    // lat counts cycles from the accepting edge to the cycle holding rsp_valid.
    task automatic run_req(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                           output int lat, output int sel_low, output logic [7:0] rd,
                           output logic err, output logic sel_k0);
        check_eq("req_ready_before", 16'(req_ready), 16'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk_main);
        req_valid = 1'b0;
        lat = -1; sel_low = 0; rd = 8'h00; err = 1'b0;
        sel_k0 = vga_select;
        check_eq("cpu_a_bus_select", 16'(cpu_a_bus), 16'(addr));
        check_eq("cpu_d_bus_select", 16'(cpu_d_bus), 16'(wd));
        check_eq("cpu_rw_select", 16'(cpu_rw), 16'(rw));
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk_main);
            if (vga_select == 1'b0) sel_low++;
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                err = rsp_error;
                check_eq("cpu_a_bus_rsp", 16'(cpu_a_bus), 16'(addr));
                check_eq("cpu_rw_rsp", 16'(cpu_rw), 16'(rw));
                check_eq("req_ready_rsp", 16'(req_ready), 16'd1);
                break;
            end
        end
        check_eq("rsp_seen", 16'(lat >= 0), 16'd1);
    endtask

    int         lat;
    int         sel_low;
    logic [7:0] rd;
    logic       err;
    logic       sel_k0;
    int         seen;

    initial begin
        reset_in_n    = 1'b0;
        req_valid     = 1'b0;
        req_rw        = 1'b0;
        req_addr      = 8'h00;
        req_wdata     = 8'h00;
        vga_d_in      = 8'h00;
        vga_interrupt = 1'b1;
        irq_clear     = 1'b0;
        #12;
        check_eq("rst_req_ready", 16'(req_ready), 16'd1);
        check_eq("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check_eq("rst_rsp_rdata", 16'(rsp_rdata), 16'h00);
        check_eq("rst_rsp_error", 16'(rsp_error), 16'd0);
        check_eq("rst_vga_select", 16'(vga_select), 16'd1);
        check_eq("rst_cpu_rw", 16'(cpu_rw), 16'd1);
        check_eq("rst_cpu_a_bus", 16'(cpu_a_bus), 16'h00);
        check_eq("rst_cpu_d_bus", 16'(cpu_d_bus), 16'h00);
        check_eq("rst_irq_pending", 16'(irq_pending), 16'd0);
        check_eq("rst_irq_status", 16'(irq_status), 16'h00);
        check_eq("rst_state", 16'(state_dbg), 16'd0);
        @(negedge clk_main);
        reset_in_n = 1'b1;
        @(negedge clk_main);

        // write 0x81 to REG_MODE_SELECT
        run_req(1'b0, 8'h00, 8'h81, lat, sel_low, rd, err, sel_k0);
        check_eq("wr_latency", 16'(lat), 16'd4);
        check_eq("wr_sel_low", 16'(sel_low), 16'd2);
        check_eq("wr_sel_k0", 16'(sel_k0), 16'd0);
        check_eq("wr_rdata", 16'(rd), 16'h00);
        check_eq("wr_error", 16'(err), 16'd0);

        // read REG_RASTER_LO, then back-to-back read of REG_RASTER_HI
        @(negedge clk_main);
        vga_d_in = 8'h3C;
        run_req(1'b1, 8'h05, 8'h00, lat, sel_low, rd, err, sel_k0);
        check_eq("rd_lo_latency", 16'(lat), 16'd4);
        check_eq("rd_lo_rdata", 16'(rd), 16'h3C);
        check_eq("rd_lo_error", 16'(err), 16'd0);
        vga_d_in = 8'h5A;
        run_req(1'b1, 8'h06, 8'h00, lat, sel_low, rd, err, sel_k0);
        check_eq("b2b_sel_k0", 16'(sel_k0), 16'd0);
        check_eq("b2b_latency", 16'(lat), 16'd4);
        check_eq("b2b_rdata", 16'(rd), 16'h5A);

        // no ack at all: SELECT times out after 8 cycles
        @(negedge clk_main);
        resp_mode = 1;
        vga_d_in  = 8'hA5;
        run_req(1'b1, 8'h02, 8'h00, lat, sel_low, rd, err, sel_k0);
        check_eq("to_sel_latency", 16'(lat), 16'd8);
        check_eq("to_sel_low", 16'(sel_low), 16'd8);
        check_eq("to_sel_error", 16'(err), 16'd1);
        check_eq("to_sel_rdata", 16'(rd), 16'h00);
        @(negedge clk_main);
        check_eq("to_sel_ready_after", 16'(req_ready), 16'd1);
        check_eq("to_sel_rsp_pulse", 16'(rsp_valid), 16'd0);

        // ack stuck low: RELEASE times out 8 cycles after the select release
        resp_mode = 2;
        vga_d_in  = 8'h77;
        run_req(1'b1, 8'h03, 8'h00, lat, sel_low, rd, err, sel_k0);
        check_eq("to_rel_latency", 16'(lat), 16'd10);
        check_eq("to_rel_sel_low", 16'(sel_low), 16'd2);
        check_eq("to_rel_error", 16'(err), 16'd1);
        check_eq("to_rel_rdata", 16'(rd), 16'h00);
        resp_mode = 0;
        repeat (2) @(negedge clk_main);
        check_eq("ack_recovered", 16'(cpu_ack), 16'd1);

        // reset while in SELECT
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h01; req_wdata = 8'h22;
        resp_mode = 1;
        @(negedge clk_main);
        req_valid = 1'b0;
        check_eq("mid_sel_low", 16'(vga_select), 16'd0);
        check_eq("mid_state", 16'(state_dbg), 16'd1);
        #2 reset_in_n = 1'b0;
        #1;
        check_eq("mid_rst_select", 16'(vga_select), 16'd1);
        check_eq("mid_rst_state", 16'(state_dbg), 16'd0);
        @(negedge clk_main);
        reset_in_n = 1'b1;
        resp_mode  = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk_main);
            if (rsp_valid) seen++;
        end
        check_eq("mid_rst_no_rsp", 16'(seen), 16'd0);
        check_eq("mid_rst_ready", 16'(req_ready), 16'd1);

`ifdef VGA_BRIDGE_IRQ_AUTOACK_EN
        // interrupt and host request together: auto-read of REG_MISC_0 goes first
        vga_d_in      = 8'h60;
        vga_interrupt = 1'b0;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h01; req_wdata = 8'h00;
        #1;
        check_eq("auto_ready_low", 16'(req_ready), 16'd0);
        seen = 0;
        for (int k = 0; k < 20 && !irq_pending; k++) begin
            @(negedge clk_main);
            if (rsp_valid) seen++;
            if (!vga_select) check_eq("auto_addr", 16'(cpu_a_bus), 16'h04);
        end
        check_eq("auto_pending", 16'(irq_pending), 16'd1);
        check_eq("auto_status", 16'(irq_status), 16'h60);
        check_eq("auto_no_rsp", 16'(seen), 16'd0);
        vga_d_in = 8'h11;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_main);
            if (!vga_select) req_valid = 1'b0;
            if (rsp_valid) begin
                lat = k;
                check_eq("host_after_auto_rdata", 16'(rsp_rdata), 16'h11);
                break;
            end
        end
        check_eq("host_after_auto_seen", 16'(lat >= 0), 16'd1);
        vga_interrupt = 1'b1;
        irq_clear     = 1'b1;
        @(negedge clk_main);
        irq_clear = 1'b0;
        check_eq("irq_cleared", 16'(irq_pending), 16'd0);
`else
        // plain interrupt tracking: one cycle of latency, clear ignored
        vga_interrupt = 1'b0;
        #1;
        check_eq("irq_not_yet", 16'(irq_pending), 16'd0);
        @(negedge clk_main);
        check_eq("irq_tracked", 16'(irq_pending), 16'd1);
        irq_clear = 1'b1;
        @(negedge clk_main);
        irq_clear = 1'b0;
        check_eq("irq_clear_ignored", 16'(irq_pending), 16'd1);
        check_eq("irq_status_zero", 16'(irq_status), 16'h00);
        check_eq("irq_no_auto_read", 16'(vga_select), 16'd1);
        vga_interrupt = 1'b1;
        @(negedge clk_main);
        check_eq("irq_released", 16'(irq_pending), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_host_bridge.md
# vga_host_bridge

Host-side initiator for the VGA controller's register port: converts single valid/ready register requests into the active-low select/acknowledge handshake (vga_select, cpu_rw, cpu_a_bus, cpu_d_bus, cpu_ack), then returns read data or a timeout error. Also tracks the controller's active-low interrupt line and can optionally service it autonomously. Sits between the CPU core's peripheral bus and the VGA controller, on the same clk_main domain.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed per handshake phase before abort; must be 2..65535.
- clk_main  in  1  system clock, shared with the VGA controller.
- reset_in_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  bridge can accept a request (IDLE only).
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  8  register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_error  out  1  qualifies rsp_valid: handshake timed out.
- vga_select  out  1  active-low transfer select.
- cpu_rw  out  1  1 = read, 0 = write.
- cpu_a_bus  out  8  register address.
- cpu_d_bus  out  8  write data.
- cpu_ack  in  1  active-low acknowledge from the controller.
- vga_d_in  in  8  controller read data, valid while cpu_ack = 0.
- vga_interrupt  in  1  active-low interrupt from the controller.
- irq_pending  out  1  interrupt outstanding.
- irq_status  out  8  last auto-read status register (macro only).
- irq_clear  in  1  clears irq_pending (macro only).

## Operation
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_error 0, vga_select 1, cpu_rw 1, cpu_a_bus 0, cpu_d_bus 0, irq_pending 0, irq_status 0; state IDLE.
- States: IDLE, SELECT, RELEASE.
  - IDLE: on req_valid && req_ready, latch rw/addr/wdata onto cpu_* and drive vga_select 0; load the timer; go to SELECT.
  - SELECT: when cpu_ack == 0, capture vga_d_in when cpu_rw = 1, or 0 otherwise; drive vga_select 1; reload the timer; go to RELEASE. On timer expiry, drive vga_select 1, then rsp_valid with rsp_error 1 and rsp_rdata 0, and return to IDLE.
  - RELEASE: when cpu_ack == 1, pulse rsp_valid with the captured data and error 0, then return to IDLE. On timer expiry, pulse rsp_valid with rsp_error 1 and return to IDLE.
- cpu_rw, cpu_a_bus and cpu_d_bus hold stable from the select-low cycle until the response cycle, inclusive.
- Timer: 16-bit down-counter loaded with TIMEOUT_CYCLES-1; expiry is count == 0 with no qualifying ack level.
- Reset mid-transfer: vga_select returns high immediately and no response is issued.
- irq_pending without the macro: register of ~vga_interrupt, one cycle of latency.

## Timing
- Accepting edge E0: vga_select low after E0.
- With a registered ack (ack low after E1): the bridge samples ack at E2 and releases select; the controller raises ack after E3; the bridge samples it at E4; rsp_valid is high in the cycle after E4.
- Minimum latency: 4 cycles from acceptance to rsp_valid.
- req_ready is high in the same cycle as rsp_valid, so back-to-back requests re-select 1 cycle after the response.
- At most one outstanding transfer.

## Configuration
- VGA_BRIDGE_IRQ_AUTOACK_EN defined:
  - In IDLE with vga_interrupt == 0 and irq_pending == 0, the bridge runs an internal read of address 0x04. This has priority over req_valid; req_ready is 0 that cycle.
  - The read data goes to irq_status and sets irq_pending; no rsp_valid is issued.
  - irq_clear clears irq_pending. If irq_clear coincides with a new set, the set wins.
  - A timeout on the auto-read leaves irq_pending 0.
- Undefined: no auto-reads; irq_status is tied 0; irq_clear is ignored.

## Structure
- Package vga_bus_pkg:
  - state enum;
  - register address constants REG_MODE_SELECT 0x00, REG_MODE_CONFIG 0x01, REG_SCROLL_X 0x02, REG_SCROLL_Y 0x03, REG_MISC_0 0x04, REG_RASTER_LO 0x05, REG_RASTER_HI 0x06;
  - active-low level constants SEL_ON/ACK_ON = 0.
- One sub-module: vga_bus_timer (loadable down-counter with an expired flag).

## Test plan
- Write 0x81 to 0x00 against a registered-ack responder -> vga_select low for exactly 2 cycles with cpu_a_bus 0x00, cpu_d_bus 0x81, cpu_rw 0; rsp_valid 4 cycles after accept, rsp_rdata 0x00, rsp_error 0.
- Read 0x05 with responder data 0x3C -> rsp_rdata 0x3C, rsp_error 0; then a back-to-back read of 0x06 -> select low 1 cycle after the first rsp_valid.
- Responder never acks, TIMEOUT_CYCLES = 8 -> select high after 8 cycles; rsp_valid with rsp_error 1 and rsp_rdata 0x00; req_ready 1 after that.
- Responder holds ack low after select release -> RELEASE times out; rsp_error 1.
- Macro on; vga_interrupt falls while req_valid is high -> auto-read of 0x04 first, irq_status 0x60, irq_pending 1; host request served next; irq_clear drops irq_pending.
- reset_in_n asserted in SELECT -> vga_select 1 asynchronously, no rsp_valid; after release, req_ready 1.
